// File: rtl/dcache_writeback_buffer.sv
// Write-back buffer: FIFO of dirty evicted lines drained to memory, with in-place
// coalescing of non-head entries and a combinational refill lookup.
module dcache_writeback_buffer #(
  parameter int unsigned ADDR_SIZE       = 32,
  parameter int unsigned CACHE_LINE_SIZE = 256,
  parameter int unsigned DEPTH           = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [ADDR_SIZE-1:0]         push_addr_i,
  input  logic [CACHE_LINE_SIZE-1:0]   push_data_i,
  input  logic [ADDR_SIZE-1:0]         lookup_addr_i,
  output logic                         lookup_hit_o,
  output logic [CACHE_LINE_SIZE-1:0]   lookup_data_o,
  output logic                         mem_valid_o,
  input  logic                         mem_ready_i,
  output logic [ADDR_SIZE-1:0]         mem_addr_o,
  output logic [CACHE_LINE_SIZE-1:0]   mem_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned OFFSET = $clog2(CACHE_LINE_SIZE / 8);
  localparam int unsigned TAG_W  = ADDR_SIZE - OFFSET;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]           valid_q;
  logic [TAG_W-1:0]           tag_q  [DEPTH];
  logic [CACHE_LINE_SIZE-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]           head_q, tail_q;
  logic [CNT_W-1:0]           count_q;

  logic [TAG_W-1:0] push_tag, lookup_tag;
  logic             push_acc, pop, coalesce, alloc;
  logic [PTR_W-1:0] coalesce_idx;
  logic             head_hit, newer_hit;
  logic [CACHE_LINE_SIZE-1:0] newer_data;
  logic             unused_offset_bits;

  assign push_tag   = push_addr_i[ADDR_SIZE-1:OFFSET];
  assign lookup_tag = lookup_addr_i[ADDR_SIZE-1:OFFSET];
  assign unused_offset_bits = ^{push_addr_i[OFFSET-1:0], lookup_addr_i[OFFSET-1:0]};

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign push_ready_o = !full_o;
  assign mem_valid_o  = !empty_o;
  assign mem_addr_o   = mem_valid_o ? {tag_q[head_q], {OFFSET{1'b0}}} : '0;
  assign mem_data_o   = mem_valid_o ? data_q[head_q] : '0;

  assign push_acc = push_valid_i && push_ready_o;
  assign pop      = mem_valid_o && mem_ready_i;
  assign alloc    = push_acc && !coalesce;

  // The head may be mid-transfer, so only newer entries are eligible for coalescing.
  always_comb begin
    coalesce     = 1'b0;
    coalesce_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (push_acc && valid_q[i] && tag_q[i] == push_tag && PTR_W'(i) != head_q) begin
        coalesce     = 1'b1;
        coalesce_idx = PTR_W'(i);
      end
    end
  end

  // A newer duplicate of the head holds the freshest data and takes priority.
  always_comb begin
    newer_hit  = 1'b0;
    newer_data = '0;
    head_hit   = valid_q[head_q] && (tag_q[head_q] == lookup_tag);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && tag_q[i] == lookup_tag && PTR_W'(i) != head_q) begin
        newer_hit  = 1'b1;
        newer_data = data_q[i];
      end
    end
    lookup_hit_o  = head_hit || newer_hit;
    lookup_data_o = newer_hit ? newer_data : (head_hit ? data_q[head_q] : '0);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (coalesce) begin
        data_q[coalesce_idx] <= push_data_i;
      end else if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tag_q[tail_q]   <= push_tag;
        data_q[tail_q]  <= push_data_i;
        tail_q          <= tail_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(alloc) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// Directed self-checking bench for dcache_writeback_buffer (default parameters).
module tb_dcache_writeback_buffer;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         push_valid_i;
  logic         push_ready_o;
  logic [31:0]  push_addr_i;
  logic [255:0] push_data_i;
  logic [31:0]  lookup_addr_i;
  logic         lookup_hit_o;
  logic [255:0] lookup_data_o;
  logic         mem_valid_o;
  logic         mem_ready_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [2:0]   count_o;
  logic         empty_o;
  logic         full_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];

  always #5 clk_i = ~clk_i;

  dcache_writeback_buffer dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .push_valid_i  (push_valid_i),
    .push_ready_o  (push_ready_o),
    .push_addr_i   (push_addr_i),
    .push_data_i   (push_data_i),
    .lookup_addr_i (lookup_addr_i),
    .lookup_hit_o  (lookup_hit_o),
    .lookup_data_o (lookup_data_o),
    .mem_valid_o   (mem_valid_o),
    .mem_ready_i   (mem_ready_i),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .count_o       (count_o),
    .empty_o       (empty_o),
    .full_o        (full_o)
  );

  function automatic logic [255:0] ln(input logic [31:0] k);
    return {8{k}};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are set at the falling edge; tick crosses one rising edge and returns at the next fall.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic push(input logic [31:0] addr, input logic [255:0] data);
    push_valid_i = 1'b1;
    push_addr_i  = addr;
    push_data_i  = data;
    tick();
    push_valid_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; push_valid_i = 1'b0; push_addr_i = '0; push_data_i = '0;
    lookup_addr_i = '0; mem_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check("rst_push_ready", push_ready_o, 1);
    check("rst_mem_valid", mem_valid_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_data", mem_data_o, 0);
    check("rst_count", count_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_lookup_hit", lookup_hit_o, 0);
    check("rst_lookup_data", lookup_data_o, 0);

    // First push becomes visible on the drain port after one edge.
    @(negedge clk_i);
    push(32'h0000_1000, ln(32'hA));
    check("a_count", count_o, 1);
    check("a_mem_valid", mem_valid_o, 1);
    check("a_mem_addr", mem_addr_o, 32'h0000_1000);
    check("a_mem_data", mem_data_o, ln(32'hA));

    // Fill and stall.
    push(32'h0000_1100, ln(32'hB));
    push(32'h0000_1200, ln(32'hC));
    push(32'h0000_1300, ln(32'hD));
    check("fill_full", full_o, 1);
    check("fill_ready", push_ready_o, 0);
    check("fill_count", count_o, 4);
    push_valid_i = 1'b1; push_addr_i = 32'h0000_1400; push_data_i = ln(32'hE);
    tick(); tick();
    check("stall_count", count_o, 4);
    check("stall_head", mem_addr_o, 32'h0000_1000);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    check("pop_count", count_o, 3);
    check("pop_ready", push_ready_o, 1);
    check("pop_head", mem_addr_o, 32'h0000_1100);
    tick();
    push_valid_i = 1'b0;
    check("fifth_count", count_o, 4);
    lookup_addr_i = 32'h0000_1400;
    #1;
    check("fifth_lookup_hit", lookup_hit_o, 1);
    check("fifth_lookup_data", lookup_data_o, ln(32'hE));
    mem_ready_i = 1'b1;
    check("drain0", mem_addr_o, 32'h0000_1100); tick();
    check("drain1", mem_addr_o, 32'h0000_1200); tick();
    check("drain2", mem_addr_o, 32'h0000_1300); tick();
    check("drain3", mem_addr_o, 32'h0000_1400);
    check("drain3_data", mem_data_o, ln(32'hE)); tick();
    mem_ready_i = 1'b0;
    check("drain_empty", empty_o, 1);

    // Interleaved pushes and pops across the pointer wrap.
    q.delete();
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      logic        exp_pop;
      a = 32'h0000_4000 + 32'(k) * 32'h40;
      push_valid_i = 1'b1; push_addr_i = a; push_data_i = ln(a);
      mem_ready_i  = (k % 2) == 1;
      exp_pop      = mem_ready_i && (q.size() > 0);
      check("wrap_ready", push_ready_o, 1);
      if (exp_pop) check("wrap_pop_addr", mem_addr_o, q[0]);
      tick();
      if (exp_pop) void'(q.pop_front());
      q.push_back(a);
      check("wrap_count", count_o, q.size());
    end
    push_valid_i = 1'b0;
    mem_ready_i  = 1'b1;
    for (int n = 0; n < 8 && q.size() > 0; n++) begin
      check("wrap_drain_addr", mem_addr_o, q[0]);
      check("wrap_drain_data", mem_data_o, ln(q[0]));
      tick();
      void'(q.pop_front());
    end
    mem_ready_i = 1'b0;
    check("wrap_end_count", count_o, 0);
    check("wrap_end_empty", empty_o, 1);

    // Coalescing: newer entries merge, the head never does.
    push(32'h0000_5000, ln(32'hA1));
    push(32'h0000_5100, ln(32'hB1));
    push(32'h0000_5100, ln(32'hB2));
    check("co_count2", count_o, 2);
    lookup_addr_i = 32'h0000_5100;
    #1;
    check("co_lookup_b", lookup_data_o, ln(32'hB2));
    push(32'h0000_5000, ln(32'hA2));
    check("co_count3", count_o, 3);
    lookup_addr_i = 32'h0000_5000;
    #1;
    check("co_lookup_a_hit", lookup_hit_o, 1);
    check("co_lookup_a", lookup_data_o, ln(32'hA2));
    check("co_head_data", mem_data_o, ln(32'hA1));
    mem_ready_i = 1'b1;
    check("co_drain0", mem_data_o, ln(32'hA1)); tick();
    check("co_drain1", mem_data_o, ln(32'hB2)); tick();
    check("co_drain2", mem_data_o, ln(32'hA2)); tick();
    mem_ready_i = 1'b0;
    check("co_empty", empty_o, 1);

    // Offset bits are ignored in the lookup compare.
    push(32'h0000_2000, ln(32'h2));
    lookup_addr_i = 32'h0000_2004;
    #1;
    check("lk_hit", lookup_hit_o, 1);
    check("lk_data", lookup_data_o, ln(32'h2));
    lookup_addr_i = 32'h0000_3000;
    #1;
    check("lk_miss_hit", lookup_hit_o, 0);
    check("lk_miss_data", lookup_data_o, 0);

    // Asynchronous reset between edges.
    push(32'h0000_2100, ln(32'h21));
    push(32'h0000_2200, ln(32'h22));
    check("ar_count_before", count_o, 3);
    check("ar_valid_before", mem_valid_o, 1);
    #2 reset_i = 1'b1;
    #1;
    check("ar_mem_valid", mem_valid_o, 0);
    check("ar_count", count_o, 0);
    check("ar_empty", empty_o, 1);
    @(negedge clk_i);
    reset_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
